vblank_update_sequencer: RTL and testbench

- Schedules the per-frame game-state updates (paddle L, paddle R, ball, score/collision) so they run only inside vertical blanking of the 1024x768 frame.
- Frame: 1344x806 at the pixel clock; vertical blanking is 38 lines = 51072 pclk cycles.
- Detects the blanking start, then issues one-hot req/done handshakes to four update tasks in fixed order.
- Enforces a per-task watchdog and flags frames whose updates spill into the active video region.

---
 rtl/vblank_update_sequencer_if.sv | 9 +
 rtl/vblank_update_sequencer.sv | 161 ++++++++++++++++
 tb/tb_vblank_update_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vblank_update_sequencer_if.sv
// Task request/acknowledge bundle between the vblank sequencer and the four
// game-state update tasks. The sequencer is the master and drives the requests.
interface vblank_update_sequencer_if;
  logic [3:0] task_req;
  logic [3:0] task_done;

  modport master (output task_req, input task_done);
  modport slave  (input task_req, output task_done);
endinterface

// File: rtl/vblank_update_sequencer.sv
// Vertical-blanking update sequencer.
// Runs paddle L, paddle R, ball and score updates in that order, one at a
// time, starting on every FRAME_DIV-th vblnk rising edge. Each task has a
// watchdog. Sticky flags report abandoned tasks and sequences that reach
// into active video.
module vblank_update_sequencer #(
  parameter int unsigned FRAME_DIV    = 1,
  parameter int unsigned TASK_TIMEOUT = 8192,
  parameter int unsigned FCNT_W       = 16
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic                      vblnk,
  input  logic                      enable,
  input  logic                      err_clear,
  vblank_update_sequencer_if.master tsk,
  output logic                      busy,
  output logic                      frame_tick,
  output logic [FCNT_W-1:0]         seq_cnt,
  output logic                      timeout_err,
  output logic                      overrun
);

  localparam int WD_W = (TASK_TIMEOUT > 1) ? $clog2(TASK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TASK0 = 3'd1,
    TASK1 = 3'd2,
    TASK2 = 3'd3,
    TASK3 = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              vblnk_d_r;
  logic [7:0]        div_r;
  logic              start_pend_r;
  logic [WD_W-1:0]   wd_r;
  logic [3:0]        task_req_r;
  logic [3:0]        task_req_s;
  logic              busy_r;
  logic              frame_tick_r;
  logic [FCNT_W-1:0] seq_cnt_r;
  logic              timeout_err_r;
  logic              overrun_r;

  logic rise_s;
  logic fall_s;
  logic start_s;
  logic cur_done_s;
  logic wd_lim_s;
  logic adv_s;
  logic timeout_s;

  // Edge detection, divider match and task completion/watchdog decode.
  always_comb begin
    rise_s     = vblnk & ~vblnk_d_r;
    fall_s     = ~vblnk & vblnk_d_r;
    start_s    = rise_s & enable & (div_r == 8'(FRAME_DIV - 1));
    // task_req_r is one-hot of the current task, so masking picks out only
    // the requested done bit and ignores the others.
    cur_done_s = |(tsk.task_done & task_req_r);
    wd_lim_s   = (wd_r == WD_W'(TASK_TIMEOUT - 1));
    adv_s      = busy_r & (cur_done_s | wd_lim_s);
    timeout_s  = busy_r & wd_lim_s & ~cur_done_s;
  end

  // vblnk delay, frame tick, game-speed divider and start request.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_d_r    <= 1'b0;
      frame_tick_r <= 1'b0;
      div_r        <= 8'd0;
      start_pend_r <= 1'b0;
    end else begin
      vblnk_d_r    <= vblnk;
      frame_tick_r <= rise_s;
      // A start edge that lands on a running sequence is dropped, not queued.
      start_pend_r <= start_s & ~busy_r;
      if (rise_s & enable) begin
        if (start_s) begin
          div_r <= 8'd0;
        end else begin
          div_r <= div_r + 8'd1;
        end
      end
    end
  end

  // Next-state and request decode; a task hands over to the next with no gap.
  always_comb begin
    state_s    = state_r;
    task_req_s = 4'b0000;
    case (state_r)
      IDLE:    if (start_pend_r) state_s = TASK0; else state_s = IDLE;
      TASK0:   if (adv_s) state_s = TASK1; else state_s = TASK0;
      TASK1:   if (adv_s) state_s = TASK2; else state_s = TASK1;
      TASK2:   if (adv_s) state_s = TASK3; else state_s = TASK2;
      TASK3:   if (adv_s) state_s = IDLE;  else state_s = TASK3;
      default: state_s = IDLE;
    endcase
    case (state_s)
      TASK0:   task_req_s = 4'b0001;
      TASK1:   task_req_s = 4'b0010;
      TASK2:   task_req_s = 4'b0100;
      TASK3:   task_req_s = 4'b1000;
      default: task_req_s = 4'b0000;
    endcase
  end

  // State register, registered request/busy, per-task watchdog, sequence count.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r    <= IDLE;
      task_req_r <= 4'b0000;
      busy_r     <= 1'b0;
      wd_r       <= WD_W'(0);
      seq_cnt_r  <= FCNT_W'(0);
    end else begin
      state_r    <= state_s;
      task_req_r <= task_req_s;
      busy_r     <= (state_s != IDLE);
      if ((state_s != state_r) || (state_r == IDLE)) begin
        wd_r <= WD_W'(0);
      end else begin
        wd_r <= wd_r + WD_W'(1);
      end
      if ((state_r == TASK3) && adv_s) begin
        seq_cnt_r <= seq_cnt_r + FCNT_W'(1);
      end
    end
  end

  // Sticky error flags; a set event in the same cycle beats err_clear.
  always_ff @(posedge pclk) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      if (timeout_s) begin
        timeout_err_r <= 1'b1;
      end else if (err_clear) begin
        timeout_err_r <= 1'b0;
      end
      if (busy_r & (rise_s | fall_s)) begin
        overrun_r <= 1'b1;
      end else if (err_clear) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign tsk.task_req = task_req_r;
  assign busy         = busy_r;
  assign frame_tick   = frame_tick_r;
  assign seq_cnt      = seq_cnt_r;
  assign timeout_err  = timeout_err_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_vblank_update_sequencer.sv
// Self-checking bench for vblank_update_sequencer. Two instances share the
// control inputs: inst 0 with FRAME_DIV=1, inst 1 with FRAME_DIV=3. Both use
// TASK_TIMEOUT=16 and FCNT_W=4. A reactive responder answers the requests,
// and a frame-level model predicts every output on every cycle.
module tb_vblank_update_sequencer;

  localparam int TO  = 16;
  localparam int MOD = 16;

  logic pclk = 1'b0;
  logic rst, vblnk, enable, err_clear;

  vblank_update_sequencer_if if_a ();
  vblank_update_sequencer_if if_b ();

  logic       busy_a, tick_a, terr_a, ovr_a;
  logic [3:0] cnt_a;
  logic       busy_b, tick_b, terr_b, ovr_b;
  logic [3:0] cnt_b;

  vblank_update_sequencer #(.FRAME_DIV(1), .TASK_TIMEOUT(TO), .FCNT_W(4)) dut_a (
    .pclk(pclk), .rst(rst), .vblnk(vblnk), .enable(enable), .err_clear(err_clear),
    .tsk(if_a), .busy(busy_a), .frame_tick(tick_a), .seq_cnt(cnt_a),
    .timeout_err(terr_a), .overrun(ovr_a));

  vblank_update_sequencer #(.FRAME_DIV(3), .TASK_TIMEOUT(TO), .FCNT_W(4)) dut_b (
    .pclk(pclk), .rst(rst), .vblnk(vblnk), .enable(enable), .err_clear(err_clear),
    .tsk(if_b), .busy(busy_b), .frame_tick(tick_b), .seq_cnt(cnt_b),
    .timeout_err(terr_b), .overrun(ovr_b));

  always #5 pclk = ~pclk;

  int errs = 0;
  int checks = 0;

  // Frame-level model state: current task index (-1 = none running) and the
  // number of cycles that task has been requested.
  int FD [2] = '{1, 3};
  int m_task [2], m_age [2], m_div [2], m_cnt [2];
  bit m_vd [2], m_pend [2], m_tick [2], m_terr [2], m_ovr [2];

  // Responder settings and state.
  bit         tie_high = 1'b0;
  bit         gate1 = 1'b0;
  logic [3:0] never_mask = 4'b0000;
  int         delay = 10;
  logic [3:0] r_prev [2];
  int         r_cnt [2];

  // Observation helpers updated every cycle.
  logic [15:0] req_log;
  logic [3:0]  last_req_a;
  int req2_cyc, ticks_a, ticks_b, starts_a, starts_b;
  bit prev_busy_a, prev_busy_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_req(input int t);
    logic [3:0] r;
    r = 4'b0000;
    if (t >= 0) r[t] = 1'b1;
    return r;
  endfunction

  task automatic model_step(input int i, input logic [3:0] d);
    bit rise, fall, busy, start, set_t;
    if (rst) begin
      m_task[i] = -1; m_age[i] = 0; m_div[i] = 0; m_cnt[i] = 0;
      m_vd[i] = 0; m_pend[i] = 0; m_tick[i] = 0; m_terr[i] = 0; m_ovr[i] = 0;
    end else begin
      rise  = vblnk && !m_vd[i];
      fall  = !vblnk && m_vd[i];
      busy  = (m_task[i] >= 0);
      start = 0;
      set_t = 0;
      if (rise && enable) begin
        if (m_div[i] == FD[i] - 1) begin m_div[i] = 0; start = 1; end
        else m_div[i]++;
      end
      if (busy) begin
        if (d[m_task[i]] || m_age[i] == TO - 1) begin
          set_t = !d[m_task[i]];
          if (m_task[i] == 3) begin m_task[i] = -1; m_cnt[i] = (m_cnt[i] + 1) % MOD; end
          else begin m_task[i]++; m_age[i] = 0; end
        end else begin
          m_age[i]++;
        end
      end else if (m_pend[i]) begin
        m_task[i] = 0; m_age[i] = 0;
      end
      m_pend[i] = start && !busy;
      m_tick[i] = rise;
      m_vd[i]   = vblnk;
      m_terr[i] = set_t ? 1'b1 : (err_clear ? 1'b0 : m_terr[i]);
      m_ovr[i]  = (busy && (rise || fall)) ? 1'b1 : (err_clear ? 1'b0 : m_ovr[i]);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [3:0] req, input logic bz, input logic tk,
                          input logic [3:0] cn, input logic te, input logic ov);
    chk($sformatf("i%0d_req", i),  {28'd0, req}, {28'd0, exp_req(m_task[i])});
    chk($sformatf("i%0d_busy", i), {31'd0, bz},  {31'd0, m_task[i] >= 0});
    chk($sformatf("i%0d_tick", i), {31'd0, tk},  {31'd0, m_tick[i]});
    chk($sformatf("i%0d_cnt", i),  {28'd0, cn},  m_cnt[i]);
    chk($sformatf("i%0d_terr", i), {31'd0, te},  {31'd0, m_terr[i]});
    chk($sformatf("i%0d_ovr", i),  {31'd0, ov},  {31'd0, m_ovr[i]});
  endtask

  function automatic logic [3:0] respond(input int i, input logic [3:0] req);
    logic [3:0] d;
    if (req != r_prev[i]) r_cnt[i] = 0; else r_cnt[i]++;
    r_prev[i] = req;
    d = 4'b0000;
    for (int b = 0; b < 4; b++)
      if (req[b] && !never_mask[b] && r_cnt[i] >= delay && !(gate1 && b == 1 && vblnk))
        d[b] = 1'b1;
    if (tie_high) d = 4'b1111;
    return d;
  endfunction

  // One clock: update the model at the edge, compare just after it, then
  // drive the responders on the falling edge.
  task automatic cycle();
    @(posedge pclk);
    model_step(0, if_a.task_done);
    model_step(1, if_b.task_done);
    #1;
    cmp_inst(0, if_a.task_req, busy_a, tick_a, cnt_a, terr_a, ovr_a);
    cmp_inst(1, if_b.task_req, busy_b, tick_b, cnt_b, terr_b, ovr_b);
    if (if_a.task_req != last_req_a && if_a.task_req != 4'b0000) req_log = {req_log[11:0], if_a.task_req};
    last_req_a = if_a.task_req;
    if (if_a.task_req == 4'b0100) req2_cyc++;
    if (tick_a) ticks_a++;
    if (tick_b) ticks_b++;
    if (busy_a && !prev_busy_a) starts_a++;
    if (busy_b && !prev_busy_b) starts_b++;
    prev_busy_a = busy_a;
    prev_busy_b = busy_b;
    @(negedge pclk);
    if_a.task_done = respond(0, if_a.task_req);
    if_b.task_done = respond(1, if_b.task_req);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic clear_obs();
    req_log = 16'h0; req2_cyc = 0; ticks_a = 0; ticks_b = 0; starts_a = 0; starts_b = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic pulse(input int hi, input int lo);
    vblnk = 1'b1;
    cycles(hi);
    vblnk = 1'b0;
    cycles(lo);
  endtask

  task automatic wait_req_a(input logic [3:0] v, input int budget);
    int n;
    n = 0;
    while (if_a.task_req != v && n < budget) begin cycle(); n++; end
    chk("wait_req_a", {28'd0, if_a.task_req}, {28'd0, v});
  endtask

  initial begin
    rst = 1'b1; vblnk = 1'b0; enable = 1'b1; err_clear = 1'b0;
    if_a.task_done = 4'b0000; if_b.task_done = 4'b0000;
    r_prev = '{4'b0000, 4'b0000}; r_cnt = '{0, 0};
    last_req_a = 4'b0000; prev_busy_a = 1'b0; prev_busy_b = 1'b0;
    clear_obs();
    @(negedge pclk);

    // Reset and first frame: done 10 cycles after each request.
    do_reset(3);
    chk("rst_req", {28'd0, if_a.task_req}, 32'd0);
    chk("rst_cnt", {28'd0, cnt_a}, 32'd0);
    delay = 10;
    vblnk = 1'b1;
    cycle();
    chk("first_tick", {31'd0, tick_a}, 32'd1);
    chk("first_nobusy", {31'd0, busy_a}, 32'd0);
    cycle();
    chk("first_req", {28'd0, if_a.task_req}, 32'h1);
    cycles(58);
    vblnk = 1'b0;
    cycles(10);
    chk("first_order", {16'd0, req_log}, 32'h1248);
    chk("first_cnt", {28'd0, cnt_a}, 32'd1);
    chk("first_terr", {31'd0, terr_a}, 32'd0);

    // Watchdog: task 2 never answers.
    do_reset(2);
    never_mask = 4'b0100; delay = 2;
    pulse(60, 10);
    chk("wd_hold", req2_cyc, 32'd16);
    chk("wd_terr", {31'd0, terr_a}, 32'd1);
    chk("wd_cnt", {28'd0, cnt_a}, 32'd1);
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    chk("wd_clear", {31'd0, terr_a}, 32'd0);
    // Done on the limit cycle wins over the watchdog.
    never_mask = 4'b0000; delay = 15; req2_cyc = 0;
    pulse(80, 10);
    chk("wd_edge_hold", req2_cyc, 32'd16);
    chk("wd_edge_terr", {31'd0, terr_a}, 32'd0);
    chk("wd_edge_cnt", {28'd0, cnt_a}, 32'd2);

    // Divider: FRAME_DIV=3 on inst 1, every task done immediately.
    do_reset(2);
    tie_high = 1'b1;
    for (int p = 0; p < 7; p++) pulse(8, 4);
    chk("div_ticks", ticks_b, 32'd7);
    chk("div_starts", starts_b, 32'd2);
    chk("div_cnt", {28'd0, cnt_b}, 32'd2);
    chk("div1_cnt", {28'd0, cnt_a}, 32'd7);
    tie_high = 1'b0;

    // Overrun: task 1 only answers once vblnk has fallen.
    do_reset(2);
    delay = 2; gate1 = 1'b1;
    vblnk = 1'b1;
    cycles(12);
    chk("ovr_before", {31'd0, ovr_a}, 32'd0);
    vblnk = 1'b0;
    cycle();
    chk("ovr_fall", {31'd0, ovr_a}, 32'd1);
    cycles(30);
    chk("ovr_cnt", {28'd0, cnt_a}, 32'd1);
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    chk("ovr_clear", {31'd0, ovr_a}, 32'd0);
    // A second rise during a busy sequence flags overrun and starts nothing.
    gate1 = 1'b0; delay = 12; starts_a = 0;
    pulse(3, 3);
    pulse(3, 70);
    chk("ovr_rise", {31'd0, ovr_a}, 32'd1);
    chk("ovr_starts", starts_a, 32'd1);
    chk("ovr_cnt2", {28'd0, cnt_a}, 32'd2);

    // Reset in the middle of TASK2, then a clean restart.
    do_reset(2);
    delay = 5;
    vblnk = 1'b1;
    wait_req_a(4'b0100, 60);
    rst = 1'b1; vblnk = 1'b0;
    cycle();
    rst = 1'b0;
    chk("mid_rst_all", {22'd0, if_a.task_req, busy_a, tick_a, cnt_a, terr_a, ovr_a}, 32'd0);
    cycles(5);
    vblnk = 1'b1;
    cycles(2);
    chk("restart_req", {28'd0, if_a.task_req}, 32'h1);
    cycles(40);
    vblnk = 1'b0;
    cycles(5);
    chk("restart_cnt", {28'd0, cnt_a}, 32'd1);

    // enable dropped during TASK1: sequence finishes, next frame only ticks.
    vblnk = 1'b1;
    wait_req_a(4'b0010, 60);
    enable = 1'b0;
    cycles(40);
    vblnk = 1'b0;
    cycles(5);
    chk("en_cnt", {28'd0, cnt_a}, 32'd2);
    clear_obs();
    pulse(30, 5);
    chk("en_ticks", ticks_a, 32'd1);
    chk("en_starts", starts_a, 32'd0);
    chk("en_cnt2", {28'd0, cnt_a}, 32'd2);
    enable = 1'b1;

    // Counter wrap at 4 bits.
    do_reset(2);
    tie_high = 1'b1;
    for (int p = 0; p < 17; p++) pulse(8, 4);
    chk("wrap_cnt", {28'd0, cnt_a}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
